// File: rtl/odometer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : odometer_pkg
// Brief    : Shared types and defaults for the odometer measurement sequencer.
// Revision : 1.0
// ============================================================================
package odometer_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int HOLD_CYCLES_DEF = 4;
  localparam int ITER_W          = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STRESS   = 3'd1,
    HANDOVER = 3'd2,
    MEAS     = 3'd3,
    HOLD     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/odometer_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : odometer_phase_timer
// Brief    : Loadable down-counter; a load of 0 counts as 1. o_last is high
//            during the final cycle of the loaded interval.
// Revision : 1.0
// ============================================================================
module odometer_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic [CNT_W-1:0] w_val;

  assign w_val = (i_load_val == '0) ? CNT_W'(1) : i_load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= w_val;
      r_last <= (w_val == CNT_W'(1));
    end else if (r_cnt > CNT_W'(1)) begin
      r_cnt  <= r_cnt - CNT_W'(1);
      r_last <= (r_cnt == CNT_W'(2));
    end
  end

  assign o_last = r_last;

endmodule
`default_nettype wire

// File: rtl/odometer_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : odometer_meas_sequencer
// Brief    : Stress / handover / measure / hold sequencer for the stacked
//            odometer. Optional multi-pass mode: ODOMETER_SEQ_REPEAT_EN.
// Revision : 1.0
// ============================================================================
module odometer_meas_sequencer
  import odometer_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             GO,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] STRESS_LEN,
  input  logic [CNT_W-1:0] MEAS_LEN,
  output logic             START,
  output logic             MEAS_STRESS,
  output logic             MEAS_DONE,
  output logic             BUSY,
  output logic             DONE
`ifdef ODOMETER_SEQ_REPEAT_EN
  ,
  input  logic [ITER_W-1:0] NUM_ITER,
  output logic [ITER_W-1:0] ITER_CNT
`endif
);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_stress_len, r_meas_len, w_load_val;
  logic             w_load, w_last, w_done, w_more, w_accept;
  logic             r_start, r_meas_stress, r_meas_done, r_busy, r_done;

  assign w_accept = (r_state == IDLE) && GO && !ABORT;

  odometer_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (CLK),
    .rst        (RESET),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_last     (w_last)
  );

`ifdef ODOMETER_SEQ_REPEAT_EN
  logic [ITER_W-1:0] r_iter_cnt, r_num_iter;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_iter_cnt <= '0;
      r_num_iter <= ITER_W'(1);
    end else if (w_accept) begin
      r_iter_cnt <= '0;
      r_num_iter <= (NUM_ITER == '0) ? ITER_W'(1) : NUM_ITER;
    end else if (r_state == HOLD && w_last && !ABORT && r_iter_cnt != '1) begin
      r_iter_cnt <= r_iter_cnt + ITER_W'(1);
    end
  end

  // Another pass remains if the pass now ending is not the last requested one.
  assign w_more   = r_iter_cnt < (r_num_iter - ITER_W'(1));
  assign ITER_CNT = r_iter_cnt;
`else
  assign w_more = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = r_stress_len;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next     = STRESS;
          w_load     = 1'b1;
          w_load_val = STRESS_LEN;
        end
      end
      STRESS: begin
        if (ABORT)       w_next = IDLE;
        else if (w_last) w_next = HANDOVER;
      end
      HANDOVER: begin
        if (ABORT) begin
          w_next = IDLE;
        end else begin
          w_next     = MEAS;
          w_load     = 1'b1;
          w_load_val = r_meas_len;
        end
      end
      MEAS: begin
        if (ABORT) begin
          w_next = IDLE;
        end else if (w_last) begin
          w_next     = HOLD;
          w_load     = 1'b1;
          w_load_val = CNT_W'(HOLD_CYCLES);
        end
      end
      HOLD: begin
        if (ABORT) begin
          w_next = IDLE;
        end else if (w_last) begin
          if (w_more) begin
            w_next     = STRESS;
            w_load     = 1'b1;
            w_load_val = r_stress_len;
          end else begin
            w_next = IDLE;
            w_done = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each phase change is glitch-free.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= IDLE;
      r_stress_len  <= '0;
      r_meas_len    <= '0;
      r_start       <= 1'b0;
      r_meas_stress <= 1'b0;
      r_meas_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_stress_len <= STRESS_LEN;
        r_meas_len   <= MEAS_LEN;
      end
      r_start       <= (w_next == STRESS) || (w_next == HANDOVER);
      r_meas_stress <= (w_next == HANDOVER) || (w_next == MEAS) || (w_next == HOLD);
      r_meas_done   <= (w_next == HOLD);
      r_busy        <= (w_next != IDLE);
      r_done        <= w_done;
    end
  end

  assign START       = r_start;
  assign MEAS_STRESS = r_meas_stress;
  assign MEAS_DONE   = r_meas_done;
  assign BUSY        = r_busy;
  assign DONE        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_odometer_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_odometer_meas_sequencer
// Brief    : Self-checking bench with a phase-offset reference model.
// Revision : 1.0
// ============================================================================
module tb_odometer_meas_sequencer;

  localparam int CNT_W = 16;
  localparam int HOLD  = 4;

  logic             CLK = 1'b0;
  logic             RESET, GO, ABORT;
  logic [CNT_W-1:0] STRESS_LEN, MEAS_LEN;
  logic             START, MEAS_STRESS, MEAS_DONE, BUSY, DONE;
`ifdef ODOMETER_SEQ_REPEAT_EN
  logic [7:0]       NUM_ITER, ITER_CNT;
`endif
  logic [4:0]       obs;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Reference model: position k (1-based) inside the current pass.
  bit m_active, m_done;
  int m_k, m_s, m_m, m_n, m_iter;

  odometer_meas_sequencer #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .GO          (GO),
    .ABORT       (ABORT),
    .STRESS_LEN  (STRESS_LEN),
    .MEAS_LEN    (MEAS_LEN),
    .START       (START),
    .MEAS_STRESS (MEAS_STRESS),
    .MEAS_DONE   (MEAS_DONE),
    .BUSY        (BUSY),
    .DONE        (DONE)
`ifdef ODOMETER_SEQ_REPEAT_EN
    ,
    .NUM_ITER    (NUM_ITER),
    .ITER_CNT    (ITER_CNT)
`endif
  );

  always #5 CLK = ~CLK;
  assign obs = {START, MEAS_STRESS, MEAS_DONE, BUSY, DONE};

  task automatic model_step();
    int tot;
    tot = m_s + 1 + m_m + HOLD;
    if (RESET) begin
      m_active = 0; m_done = 0; m_iter = 0; m_k = 0; m_s = 0; m_m = 0;
    end else if (m_active) begin
      m_done = 0;
      if (ABORT) m_active = 0;
      else if (m_k == tot) begin
        if (m_iter < 255) m_iter++;
        if (m_iter < m_n) m_k = 1;
        else begin m_active = 0; m_done = 1; end
      end else m_k++;
    end else begin
      m_done = 0;
      if (GO && !ABORT) begin
        m_active = 1; m_k = 1; m_iter = 0;
        m_s = (STRESS_LEN == 0) ? 1 : int'(STRESS_LEN);
        m_m = (MEAS_LEN == 0) ? 1 : int'(MEAS_LEN);
`ifdef ODOMETER_SEQ_REPEAT_EN
        m_n = (NUM_ITER == 0) ? 1 : int'(NUM_ITER);
`else
        m_n = 1;
`endif
      end
    end
  endtask

  function automatic logic [4:0] exp_outs();
    if (!m_active) return {4'b0000, m_done};
    return {(m_k <= m_s + 1), (m_k >= m_s + 1), (m_k > m_s + 1 + m_m), 1'b1, 1'b0};
  endfunction

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1; GO = 0; ABORT = 0; STRESS_LEN = 0; MEAS_LEN = 0;
    tick(); tick();
    total_cnt++;
    if (obs !== 5'b0) begin
      bad_cnt++; $display("FAIL reset_outs got=%b exp=%b", obs, 5'b0);
    end
`ifdef ODOMETER_SEQ_REPEAT_EN
    total_cnt++;
    if (ITER_CNT !== 8'd0) begin
      bad_cnt++; $display("FAIL reset_iter got=%0d exp=0", ITER_CNT);
    end
`endif
    RESET = 0;
    tick();
  endtask

  task automatic test_basic(input int s, input int m, input int exp_busy);
    int busy_n = 0, done_n = 0;
    STRESS_LEN = CNT_W'(s); MEAS_LEN = CNT_W'(m); GO = 1;
    tick();
    GO = 0;
    for (int i = 0; i < exp_busy + 4; i++) begin
      total_cnt++;
      if (obs !== exp_outs()) begin
        bad_cnt++; $display("FAIL basic_s%0d_m%0d cyc=%0d got=%b exp=%b", s, m, i, obs, exp_outs());
      end
      busy_n += int'(BUSY); done_n += int'(DONE);
      tick();
    end
    total_cnt++;
    if (busy_n != exp_busy || done_n != 1) begin
      bad_cnt++; $display("FAIL basic_len busy=%0d done=%0d exp busy=%0d done=1", busy_n, done_n, exp_busy);
    end
  endtask

  task automatic test_abort();
    STRESS_LEN = 3; MEAS_LEN = 4; GO = 1;
    tick();
    GO = 0;
    for (int i = 0; i < 5; i++) tick();  // now in 2nd MEAS cycle
    total_cnt++;
    if (obs !== 5'b01010) begin
      bad_cnt++; $display("FAIL abort_pre got=%b exp=%b", obs, 5'b01010);
    end
    ABORT = 1;
    tick();
    ABORT = 0;
    total_cnt++;
    if (obs !== 5'b0 || obs !== exp_outs()) begin
      bad_cnt++; $display("FAIL abort_outs got=%b exp=%b", obs, 5'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (obs !== exp_outs()) begin
        bad_cnt++; $display("FAIL abort_idle cyc=%0d got=%b exp=%b", i, obs, exp_outs());
      end
    end
    test_basic(2, 1, 8);
  endtask

  task automatic test_go_abort_and_ignore();
    GO = 1; ABORT = 1; STRESS_LEN = 2; MEAS_LEN = 2;
    tick();
    GO = 0; ABORT = 0;
    total_cnt++;
    if (obs !== 5'b0) begin
      bad_cnt++; $display("FAIL go_abort got=%b exp=%b", obs, 5'b0);
    end
    GO = 1;
    tick();
    GO = 0;
    for (int i = 0; i < 14; i++) begin
      // Pulse GO and disturb lengths mid-sequence; neither may affect it.
      GO = (i == 5); STRESS_LEN = 9; MEAS_LEN = 0;
      total_cnt++;
      if (obs !== exp_outs()) begin
        bad_cnt++; $display("FAIL go_ignore cyc=%0d got=%b exp=%b", i, obs, exp_outs());
      end
      tick();
    end
    GO = 0;
  endtask

  task automatic test_reset_mid();
    STRESS_LEN = 8; MEAS_LEN = 2; GO = 1;
    tick();
    GO = 0;
    tick(); tick();
    RESET = 1;
    tick();
    RESET = 0;
    total_cnt++;
    if (obs !== 5'b0) begin
      bad_cnt++; $display("FAIL reset_mid got=%b exp=%b", obs, 5'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (obs !== exp_outs()) begin
        bad_cnt++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, exp_outs());
      end
    end
  endtask

  task automatic test_back_to_back();
    STRESS_LEN = 1; MEAS_LEN = 2; GO = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      total_cnt++;
      if (obs !== exp_outs()) begin
        bad_cnt++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, obs, exp_outs());
      end
    end
    GO = 0;
    for (int i = 0; i < 10; i++) tick();
  endtask

`ifdef ODOMETER_SEQ_REPEAT_EN
  task automatic test_repeat();
    int done_n = 0;
    NUM_ITER = 3; STRESS_LEN = 2; MEAS_LEN = 2; GO = 1;
    tick();
    GO = 0;
    for (int i = 0; i < 30; i++) begin
      total_cnt++;
      if (obs !== exp_outs() || ITER_CNT !== 8'(m_iter)) begin
        bad_cnt++; $display("FAIL repeat cyc=%0d got=%b/%0d exp=%b/%0d", i, obs, ITER_CNT, exp_outs(), m_iter);
      end
      done_n += int'(DONE);
      tick();
    end
    total_cnt++;
    if (done_n != 1 || ITER_CNT !== 8'd3) begin
      bad_cnt++; $display("FAIL repeat_end done=%0d iter=%0d exp done=1 iter=3", done_n, ITER_CNT);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      GO         = ($urandom_range(0, 3) == 0);
      ABORT      = ($urandom_range(0, 40) == 0);
      RESET      = ($urandom_range(0, 150) == 0);
      STRESS_LEN = CNT_W'($urandom_range(0, 6));
      MEAS_LEN   = CNT_W'($urandom_range(0, 6));
`ifdef ODOMETER_SEQ_REPEAT_EN
      NUM_ITER   = 8'($urandom_range(0, 3));
`endif
      tick();
      total_cnt++;
      if (obs !== exp_outs()) begin
        bad_cnt++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, exp_outs());
      end
`ifdef ODOMETER_SEQ_REPEAT_EN
      total_cnt++;
      if (ITER_CNT !== 8'(m_iter)) begin
        bad_cnt++; $display("FAIL random_iter cyc=%0d got=%0d exp=%0d", i, ITER_CNT, m_iter);
      end
`endif
    end
    RESET = 0; GO = 0; ABORT = 0;
  endtask

  initial begin
    RESET = 1; GO = 0; ABORT = 0; STRESS_LEN = 0; MEAS_LEN = 0;
    m_active = 0; m_done = 0; m_k = 0; m_s = 0; m_m = 0; m_n = 1; m_iter = 0;
`ifdef ODOMETER_SEQ_REPEAT_EN
    NUM_ITER = 1;
`endif
    test_reset();
    test_basic(5, 3, 13);
    test_basic(0, 0, 7);
    test_abort();
    test_go_abort_and_ignore();
    test_reset_mid();
    test_back_to_back();
`ifdef ODOMETER_SEQ_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
